// File: rtl/pipe_int_mul_pkg.sv
// Shared constants and helpers for the pipelined integer multiplier response path.
package pipe_int_mul_pkg;

  localparam int PRODUCT_W          = 64;
  localparam int RESP_DEPTH_DEFAULT = 4;

  // Pointer width for a modulo-depth counter; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pipe_int_mul_resp_queue_if.sv
// Handshake bundle between the multiplier MP stage, the response queue and its consumer.
interface pipe_int_mul_resp_queue_if #(
  parameter int PW = 64
);
  // Both sides use val/rdy: a transfer happens on a rising clock edge where val
  // and rdy are both high; a producer holding val keeps its data stable until then.
  logic          mp_val;
  logic [PW-1:0] mp_product;
  logic          mp_rdy;
  logic          resp_val;
  logic          resp_rdy;
  logic [PW-1:0] resp_product;

  // master: multiplier plus consumer environment; slave: the queue itself.
  modport master (
    output mp_val, mp_product, resp_rdy,
    input  mp_rdy, resp_val, resp_product
  );

  modport slave (
    input  mp_val, mp_product, resp_rdy,
    output mp_rdy, resp_val, resp_product
  );

endinterface

// File: rtl/pipe_int_mul_ptr_ctr.sv
// Modulo-DEPTH wrap counter used for the queue read and write pointers.
module pipe_int_mul_ptr_ctr
  import pipe_int_mul_pkg::*;
#(
  parameter int  DEPTH = RESP_DEPTH_DEFAULT,
  localparam int PTR_W = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  // Explicit compare so non power-of-2 depths wrap correctly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/pipe_int_mul_resp_queue.sv
// In-order product queue behind the multiplier MP stage with val/rdy on both sides.
// Optional same-cycle pass-through when empty: define PIPE_MUL_RESP_BYPASS_EN.
module pipe_int_mul_resp_queue
  import pipe_int_mul_pkg::*;
#(
  parameter int  DEPTH = RESP_DEPTH_DEFAULT,
  parameter int  PW    = PRODUCT_W,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PTR_W = ptr_w(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  pipe_int_mul_resp_queue_if.slave   bus,
  output logic [CW-1:0]              count
);

  logic [PW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             full;
  logic             enq;
  logic             deq;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // mp_rdy comes from registered state only, so a pop while full frees space next cycle.
  assign bus.mp_rdy = ~full;

`ifdef PIPE_MUL_RESP_BYPASS_EN
  logic pass_thru;

  // reset gates the empty-queue path so outputs stay quiet while reset is held.
  assign pass_thru        = empty & reset & bus.mp_val & bus.resp_rdy;
  assign bus.resp_val     = ~empty | (reset & bus.mp_val);
  assign bus.resp_product = !empty                 ? mem[rd_ptr]    :
                            (reset & bus.mp_val)   ? bus.mp_product : '0;
  assign enq              = bus.mp_val & bus.mp_rdy & ~pass_thru;
  assign deq              = ~empty & bus.resp_rdy;
`else
  assign bus.resp_val     = ~empty;
  assign bus.resp_product = empty ? '0 : mem[rd_ptr];
  assign enq              = bus.mp_val & bus.mp_rdy;
  assign deq              = bus.resp_val & bus.resp_rdy;
`endif

  pipe_int_mul_ptr_ctr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (enq),
    .ptr   (wr_ptr)
  );

  pipe_int_mul_ptr_ctr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (deq),
    .ptr   (rd_ptr)
  );

  // Storage is deliberately not reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= bus.mp_product;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (enq && !deq) begin
      count <= count + CW'(1);
    end else if (deq && !enq) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_pipe_int_mul_resp_queue.sv
// Directed and randomized checks of the response queue against an in-bench FIFO scoreboard.
module tb_pipe_int_mul_resp_queue;

  logic clk;
  logic reset;
  logic [2:0] count_a;
  logic [1:0] count_b;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_qa[$];
  logic [63:0] exp_qb[$];
  logic [63:0] wrap_vals[10];

  pipe_int_mul_resp_queue_if #(.PW(64)) aif ();
  pipe_int_mul_resp_queue_if #(.PW(64)) bif ();

  pipe_int_mul_resp_queue #(.DEPTH(4), .PW(64)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (aif),
    .count (count_a)
  );

  pipe_int_mul_resp_queue #(.DEPTH(3), .PW(64)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bif),
    .count (count_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at the falling edge, sample after settling, score against the model.
  task automatic step(input bit use_b, input logic v, input logic [63:0] d,
                      input logic r, output bit acc);
    int          sz;
    int          depth;
    logic [63:0] obs_cnt;
    logic        obs_rdy;
    logic        obs_val;
    logic [63:0] obs_prod;
    logic [63:0] head;
    bit          do_pop;
    bit          do_push;
    @(negedge clk);
    if (use_b) begin
      bif.mp_val = v; bif.mp_product = d; bif.resp_rdy = r;
    end else begin
      aif.mp_val = v; aif.mp_product = d; aif.resp_rdy = r;
    end
    #1;
    if (use_b) begin
      depth = 3; sz = exp_qb.size(); head = (sz != 0) ? exp_qb[0] : 64'd0;
      obs_cnt = 64'(count_b); obs_rdy = bif.mp_rdy; obs_val = bif.resp_val; obs_prod = bif.resp_product;
    end else begin
      depth = 4; sz = exp_qa.size(); head = (sz != 0) ? exp_qa[0] : 64'd0;
      obs_cnt = 64'(count_a); obs_rdy = aif.mp_rdy; obs_val = aif.resp_val; obs_prod = aif.resp_product;
    end
    check(use_b ? "b_count" : "a_count", obs_cnt, 64'(sz));
    check(use_b ? "b_mp_rdy" : "a_mp_rdy", 64'(obs_rdy), 64'(sz != depth));
    acc = v && (sz != depth);
    do_pop = (sz != 0) && r;
    if (sz != 0) begin
      check(use_b ? "b_resp_val" : "a_resp_val", 64'(obs_val), 64'd1);
      check(use_b ? "b_resp_product" : "a_resp_product", obs_prod, head);
      do_push = acc;
    end else begin
`ifdef PIPE_MUL_RESP_BYPASS_EN
      check(use_b ? "b_byp_val" : "a_byp_val", 64'(obs_val), 64'(v));
      check(use_b ? "b_byp_product" : "a_byp_product", obs_prod, v ? d : 64'd0);
      do_push = acc && !r;
`else
      check(use_b ? "b_empty_val" : "a_empty_val", 64'(obs_val), 64'd0);
      check(use_b ? "b_empty_product" : "a_empty_product", obs_prod, 64'd0);
      do_push = acc;
`endif
    end
    if (use_b) begin
      if (do_pop) void'(exp_qb.pop_front());
      if (do_push) exp_qb.push_back(d);
    end else begin
      if (do_pop) void'(exp_qa.pop_front());
      if (do_push) exp_qa.push_back(d);
    end
  endtask

  initial begin
    bit acc;
    int n_in;
    reset = 1'b0;
    aif.mp_val = 1'b1; aif.mp_product = 64'hDEAD_BEEF; aif.resp_rdy = 1'b0;
    bif.mp_val = 1'b1; bif.mp_product = 64'hFEED_F00D; bif.resp_rdy = 1'b0;

    // reset held with a valid product offered: nothing taken, outputs idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp_val", 64'(aif.resp_val), 64'd0);
    check("rst_resp_product", aif.resp_product, 64'd0);
    check("rst_count", 64'(count_a), 64'd0);
    check("rst_mp_rdy", 64'(aif.mp_rdy), 64'd1);
    check("rst_count_b", 64'(count_b), 64'd0);
    aif.mp_val = 1'b0; bif.mp_val = 1'b0;
    reset = 1'b1;
    step(0, 1'b0, 64'd0, 1'b0, acc);
    step(1, 1'b0, 64'd0, 1'b0, acc);

    // single product through with consumer ready
    step(0, 1'b1, 64'h0000_0001_0000_0002, 1'b1, acc);
    step(0, 1'b0, 64'd0, 1'b1, acc);
    step(0, 1'b0, 64'd0, 1'b0, acc);

    // fill to DEPTH, hold a fifth product until space opens, then drain in order
    for (int i = 1; i <= 4; i++) step(0, 1'b1, 64'(i), 1'b0, acc);
    step(0, 1'b1, 64'd5, 1'b0, acc);
    check("fill_held", 64'(acc), 64'd0);
    step(0, 1'b1, 64'd5, 1'b1, acc);
    check("full_pop_no_push", 64'(acc), 64'd0);
    step(0, 1'b1, 64'd5, 1'b1, acc);
    check("fifth_taken", 64'(acc), 64'd1);
    for (int i = 0; i < 5; i++) step(0, 1'b0, 64'd0, 1'b1, acc);
    check("fill_drained", 64'(exp_qa.size()), 64'd0);
    step(0, 1'b0, 64'd0, 1'b0, acc);

    // depth-3 queue, random valid/ready, ten values through so both pointers wrap
    for (int i = 0; i < 10; i++) wrap_vals[i] = {$urandom, $urandom};
    n_in = 0;
    for (int cyc = 0; cyc < 400 && (n_in < 10 || exp_qb.size() != 0); cyc++) begin
      step(1, (n_in < 10) && ($urandom_range(0, 2) != 0),
           wrap_vals[(n_in < 10) ? n_in : 9], $urandom_range(0, 2) != 0, acc);
      if (acc) n_in++;
    end
    check("wrap_all_sent", 64'(n_in), 64'd10);
    check("wrap_drained", 64'(exp_qb.size()), 64'd0);
    step(1, 1'b0, 64'd0, 1'b0, acc);

    // simultaneous enqueue and dequeue with one entry: new value becomes head
    step(0, 1'b1, 64'hAA, 1'b0, acc);
    step(0, 1'b1, 64'hBB, 1'b1, acc);
    step(0, 1'b0, 64'd0, 1'b0, acc);
    check("simul_head", aif.resp_product, 64'hBB);
    check("simul_count", 64'(count_a), 64'd1);
    step(0, 1'b0, 64'd0, 1'b1, acc);

    // empty queue, product offered with consumer ready: latency depends on build
    step(0, 1'b1, 64'h77, 1'b1, acc);
    step(0, 1'b0, 64'd0, 1'b1, acc);
    step(0, 1'b0, 64'd0, 1'b0, acc);

    // mid-operation reset discards contents immediately
    for (int i = 0; i < 3; i++) step(0, 1'b1, 64'h100 + 64'(i), 1'b0, acc);
    step(0, 1'b0, 64'd0, 1'b0, acc);
    check("pre_mid_rst_count", 64'(count_a), 64'd3);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_resp_val", 64'(aif.resp_val), 64'd0);
    check("mid_rst_count", 64'(count_a), 64'd0);
    check("mid_rst_mp_rdy", 64'(aif.mp_rdy), 64'd1);
    exp_qa.delete();
    exp_qb.delete();
    @(negedge clk);
    reset = 1'b1;
    step(0, 1'b0, 64'd0, 1'b0, acc);
    step(0, 1'b1, 64'h55, 1'b0, acc);
    step(0, 1'b0, 64'd0, 1'b1, acc);
    step(0, 1'b0, 64'd0, 1'b0, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
